// File: rtl/squeeze_bias_sequencer_if.sv
// Stream bundle between the squeeze MAC array, the bias/activation sequencer
// and the expand-layer input buffer. The accumulator side and the activation
// side each use a valid/ready pair. The sequencer is the "slave" modport: it
// sinks accumulator beats and sources activations.
interface squeeze_bias_sequencer_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int CH_W  = 6
);
    logic [ACC_W-1:0] acc_data;
    logic             acc_valid;
    logic             acc_ready;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_valid;
    logic             out_ready;

    // Environment side: drives accumulator beats and downstream ready.
    modport master (
        output acc_data, acc_valid, out_ready,
        input  acc_ready, out_data, out_ch, out_valid
    );

    // Sequencer side: accepts accumulator beats, emits activations.
    modport slave (
        input  acc_data, acc_valid, out_ready,
        output acc_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/squeeze_bias_sequencer.sv
// fire7 squeeze-layer bias/activation sequencer.
// Accepts channel-major accumulator results and adds the per-channel
// sign-magnitude bias. It applies optional ReLU and saturation, then emits
// OUT_W-bit activations through a one-deep output register. One layer pass of
// CH*PIXELS beats is framed by each start pulse.
module squeeze_bias_sequencer #(
    parameter int CH     = 64,
    parameter int PIXELS = 169,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int RELU   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH-1:0][15:0]  bias_mem,
    squeeze_bias_sequencer_if.slave bus,
    output logic                 busy,
    output logic                 done
);
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS + 1) : 1;
    localparam bit RELU_EN = (RELU != 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Sign-magnitude bias to ACC_W+1-bit two's complement; -0 folds to 0.
    function automatic logic signed [ACC_W:0] bias_ext(input logic [15:0] b);
        logic signed [ACC_W:0] mag;
        mag = {{(ACC_W - 14){1'b0}}, b[14:0]};
        if (b[15]) begin
            bias_ext = -mag;
        end else begin
            bias_ext = mag;
        end
    endfunction

    // ReLU (when enabled) followed by saturation to the OUT_W range.
    function automatic logic [OUT_W-1:0] activate(input logic signed [ACC_W:0] s);
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        hi = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
        lo = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
        if (RELU_EN && s[ACC_W]) begin
            activate = '0;
        end else if (s > hi) begin
            activate = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (s < lo) begin
            activate = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            activate = s[OUT_W-1:0];
        end
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [CH_W-1:0]      ch_cnt_r;
    logic [PIX_W-1:0]     pix_cnt_r;
    logic [OUT_W-1:0]     out_data_r;
    logic [CH_W-1:0]      out_ch_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 acc_ready_s;
    logic                 in_xfer_s;
    logic                 out_xfer_s;
    logic                 last_beat_s;
    logic signed [ACC_W:0] acc_ext_s;
    logic signed [ACC_W:0] sum_s;
    logic [OUT_W-1:0]     act_s;

    // Handshake qualifiers, end-of-pass detect and the bias/activation datapath.
    always_comb begin
        acc_ready_s = (state_r == ST_RUN) && (!out_valid_r || bus.out_ready);
        in_xfer_s   = bus.acc_valid && acc_ready_s;
        out_xfer_s  = out_valid_r && bus.out_ready;
        last_beat_s = (ch_cnt_r == CH_W'(CH - 1)) && (pix_cnt_r == PIX_W'(PIXELS - 1));
        acc_ext_s   = {bus.acc_data[ACC_W-1], bus.acc_data};
        sum_s       = acc_ext_s + bias_ext(bias_mem[ch_cnt_r]);
        act_s       = activate(sum_s);
    end

    // Next-state logic for the pass framing FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_xfer_s && last_beat_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_xfer_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done status derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Channel/pixel position of the next input beat; cleared while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_r  <= '0;
            pix_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            ch_cnt_r  <= '0;
            pix_cnt_r <= '0;
        end else if (in_xfer_s) begin
            if (ch_cnt_r == CH_W'(CH - 1)) begin
                ch_cnt_r  <= '0;
                pix_cnt_r <= pix_cnt_r + PIX_W'(1);
            end else begin
                ch_cnt_r  <= ch_cnt_r + CH_W'(1);
            end
        end
    end

    // One-deep output register: a new beat overwrites it even while draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
        end else if (in_xfer_s) begin
            out_data_r  <= act_s;
            out_ch_r    <= ch_cnt_r;
            out_valid_r <= 1'b1;
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.acc_ready = acc_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_squeeze_bias_sequencer.sv
// Directed bench for squeeze_bias_sequencer. dut0 is the production
// configuration (RELU=1, 64x169). dut1 is a one-pixel RELU=0 instance for
// the sign-preserving cases.
`timescale 1ns/1ps
module tb_squeeze_bias_sequencer;
    localparam int CH     = 64;
    localparam int PIXELS = 169;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int CH_W   = 6;
    localparam int TOTAL  = CH * PIXELS;
    localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_DRAIN = 2'd2, M_DONE = 2'd3;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    logic busy0, done0, busy1, done1;
    logic [CH-1:0][15:0] bias0, bias1;

    squeeze_bias_sequencer_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .CH_W(CH_W)) if0 ();
    squeeze_bias_sequencer_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .CH_W(CH_W)) if1 ();

    squeeze_bias_sequencer #(.CH(CH), .PIXELS(PIXELS), .ACC_W(ACC_W), .OUT_W(OUT_W), .RELU(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .bias_mem(bias0), .bus(if0), .busy(busy0), .done(done0));
    squeeze_bias_sequencer #(.CH(CH), .PIXELS(1), .ACC_W(ACC_W), .OUT_W(OUT_W), .RELU(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bias_mem(bias1), .bus(if1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_tab [TOTAL];

    // Reference model of dut0 (expected values computed from the stimulus)
    logic [1:0]  m_state;
    logic        m_valid;
    logic [15:0] m_data;
    logic [5:0]  m_ch;
    int          m_k;
    int          out_count, ch63_count, done_count;

    // Per-cycle snapshot: s_* observed, e_* expected
    logic s_ready, s_valid, s_busy, s_done;
    logic [15:0] s_data;
    logic [5:0]  s_ch;
    logic e_ready, e_valid, e_busy, e_done;
    logic [15:0] e_data;
    logic [5:0]  e_ch;

    function automatic logic [15:0] exp_act(input int acc, input logic [15:0] b, input bit relu);
        longint bv;
        longint s;
        bv = 64'sd0;
        bv[14:0] = b[14:0];
        if (b[15]) bv = -bv;
        s = longint'(acc) + bv;
        if (relu && s < 64'sd0) return 16'h0000;
        if (s > 64'sd32767) return 16'h7FFF;
        if (s < -64'sd32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_ch    = 6'd0;
        m_k     = 0;
    endtask

    // Drives one cycle of dut0, snapshots outputs and advances the model.
    task automatic drive_cycle(input bit av, input bit ordy, input bit st);
        bit m_in, m_out;
        start0 = st;
        if0.acc_valid = av;
        if0.out_ready = ordy;
        if0.acc_data  = (m_k < TOTAL) ? acc_tab[m_k] : 32'h0;
        #1;
        s_ready = if0.acc_ready; s_valid = if0.out_valid; s_data = if0.out_data;
        s_ch = if0.out_ch; s_busy = busy0; s_done = done0;
        e_ready = (m_state == M_RUN) && (!m_valid || ordy);
        e_valid = m_valid; e_data = m_data; e_ch = m_ch;
        e_busy = (m_state != M_IDLE); e_done = (m_state == M_DONE);
        m_in  = av && e_ready;
        m_out = m_valid && ordy;
        if (s_done) done_count++;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        if (m_out) begin
            out_count++;
            if (m_ch == 6'd63) ch63_count++;
        end
        case (m_state)
            M_IDLE:  if (st) begin m_state = M_RUN; m_k = 0; end
            M_RUN:   if (m_in && m_k == TOTAL - 1) m_state = M_DRAIN;
            M_DRAIN: if (m_out) m_state = M_DONE;
            default: m_state = M_IDLE;
        endcase
        if (m_in) begin
            m_data  = exp_act(acc_tab[m_k], bias0[m_k % CH], 1'b1);
            m_ch    = 6'(m_k % CH);
            m_valid = 1'b1;
            m_k++;
        end else if (m_out) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        if0.acc_valid = 1'b0; if0.acc_data = 32'h0; if0.out_ready = 1'b0;
        if1.acc_valid = 1'b0; if1.acc_data = 32'h0; if1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (if0.acc_ready !== 1'b0 || if0.out_valid !== 1'b0 || if0.out_data !== 16'h0 ||
            if0.out_ch !== 6'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut0 got rdy=%b vld=%b data=%h ch=%0d busy=%b done=%b exp all 0",
                     if0.acc_ready, if0.out_valid, if0.out_data, if0.out_ch, busy0, done0);
        end
        checks++;
        if (if1.acc_ready !== 1'b0 || if1.out_valid !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1 got rdy=%b vld=%b busy=%b done=%b exp all 0",
                     if1.acc_ready, if1.out_valid, busy1, done1);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_relu_off();
        logic [15:0] exp;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL relu_off_busy got %b exp 1", busy1);
        end
        if1.out_ready = 1'b1;
        if1.acc_valid = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (c == 0) begin
                if1.acc_data = -32'sd40000; exp = 16'h8000;
            end else if (c == 36) begin
                if1.acc_data = 32'sd300; exp = 16'hFF2F;
            end else begin
                if1.acc_data = 32'(c * 3); exp = 16'(c * 3);
            end
            @(posedge clk);
            #1;
            checks++;
            if (if1.out_valid !== 1'b1 || if1.out_data !== exp || if1.out_ch !== 6'(c)) begin
                errors++;
                $display("FAIL relu_off_ch%0d got vld=%b data=%h ch=%0d exp vld=1 data=%h ch=%0d",
                         c, if1.out_valid, if1.out_data, if1.out_ch, exp, c);
            end
        end
        if1.acc_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b1 || if1.out_valid !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL relu_off_done got done=%b vld=%b busy=%b exp 1 0 1", done1, if1.out_valid, busy1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL relu_off_idle got done=%b busy=%b exp 0 0", done1, busy1);
        end
    endtask

    task automatic test_basic();
        out_count = 0; ch63_count = 0; done_count = 0;
        drive_cycle(1'b0, 1'b1, 1'b1);
        for (int k = 0; k <= 38; k++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            checks++;
            if (s_ready !== e_ready || s_valid !== e_valid || s_busy !== e_busy || s_done !== e_done ||
                (e_valid && (s_data !== e_data || s_ch !== e_ch))) begin
                errors++;
                $display("FAIL basic_cycle k=%0d got rdy=%b vld=%b data=%h ch=%0d busy=%b done=%b exp %b %b %h %0d %b %b",
                         k, s_ready, s_valid, s_data, s_ch, s_busy, s_done, e_ready, e_valid, e_data, e_ch, e_busy, e_done);
            end
            if (k == 0) begin
                checks++;
                if (s_busy !== 1'b1 || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_start got busy=%b rdy=%b exp 1 1", s_busy, s_ready);
                end
            end
            if (k == 1) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== 16'h0006 || s_ch !== 6'd0) begin
                    errors++;
                    $display("FAIL basic_bias got vld=%b data=%h ch=%0d exp 1 0006 0", s_valid, s_data, s_ch);
                end
            end
            if (k == 37) begin
                checks++;
                if (s_data !== 16'h0000 || s_ch !== 6'd36) begin
                    errors++;
                    $display("FAIL relu_clamp got data=%h ch=%0d exp 0000 36", s_data, s_ch);
                end
            end
            if (k == 38) begin
                checks++;
                if (s_data !== 16'h7FFF || s_ch !== 6'd37) begin
                    errors++;
                    $display("FAIL saturate_hi got data=%h ch=%0d exp 7fff 37", s_data, s_ch);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held_data;
        logic [5:0]  held_ch;
        held_data = 16'h0; held_ch = 6'd0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                held_data = e_data; held_ch = e_ch;
            end
            checks++;
            if (s_ready !== 1'b0 || s_valid !== 1'b1 || s_data !== held_data || s_ch !== held_ch) begin
                errors++;
                $display("FAIL backpressure_hold i=%0d got rdy=%b vld=%b data=%h ch=%0d exp 0 1 %h %0d",
                         i, s_ready, s_valid, s_data, s_ch, held_data, held_ch);
            end
        end
        for (int i = 0; i < 200; i++) begin
            drive_cycle(1'b1, (i % 2) == 0, 1'b0);
            checks++;
            if (s_ready !== e_ready || s_valid !== e_valid || s_busy !== e_busy || s_done !== e_done ||
                (e_valid && (s_data !== e_data || s_ch !== e_ch))) begin
                errors++;
                $display("FAIL toggle_cycle i=%0d got rdy=%b vld=%b data=%h ch=%0d exp %b %b %h %0d",
                         i, s_ready, s_valid, s_data, s_ch, e_ready, e_valid, e_data, e_ch);
            end
        end
    endtask

    task automatic test_framing();
        int cyc;
        bit seen_done;
        cyc = 0;
        seen_done = 1'b0;
        while (!(seen_done && m_state == M_IDLE) && cyc < 60000) begin
            drive_cycle($urandom_range(0, 3) != 0, cyc[0], cyc == 1000);
            checks++;
            if (s_ready !== e_ready || s_valid !== e_valid || s_busy !== e_busy || s_done !== e_done ||
                (e_valid && (s_data !== e_data || s_ch !== e_ch))) begin
                errors++;
                $display("FAIL framing_cycle c=%0d got rdy=%b vld=%b data=%h ch=%0d busy=%b done=%b exp %b %b %h %0d %b %b",
                         cyc, s_ready, s_valid, s_data, s_ch, s_busy, s_done, e_ready, e_valid, e_data, e_ch, e_busy, e_done);
            end
            if (s_done) seen_done = 1'b1;
            cyc++;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL framing_timeout got no done in %0d cycles exp done", cyc);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (s_busy !== 1'b0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL framing_idle got busy=%b done=%b exp 0 0", s_busy, s_done);
        end
        checks++;
        if (out_count !== TOTAL || ch63_count !== PIXELS || done_count !== 1) begin
            errors++;
            $display("FAIL framing_counts got outs=%0d ch63=%0d dones=%0d exp %0d %0d 1",
                     out_count, ch63_count, done_count, TOTAL, PIXELS);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        cyc = 0;
        done_count = 0;
        drive_cycle(1'b0, 1'b1, 1'b1);
        while (m_k < 50 * CH && cyc < 10000) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            cyc++;
        end
        checks++;
        if (s_valid !== 1'b1 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_prep got vld=%b busy=%b exp 1 1", s_valid, s_busy);
        end
        rst = 1'b1;
        if0.acc_valid = 1'b0;
        #1;
        checks++;
        if (if0.acc_ready !== 1'b0 || if0.out_valid !== 1'b0 || if0.out_data !== 16'h0 ||
            if0.out_ch !== 6'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear got rdy=%b vld=%b data=%h ch=%0d busy=%b done=%b exp all 0",
                     if0.acc_ready, if0.out_valid, if0.out_data, if0.out_ch, busy0, done0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (s_done !== 1'b0 || s_busy !== 1'b0 || s_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_nodone i=%0d got done=%b busy=%b vld=%b exp 0 0 0", i, s_done, s_busy, s_valid);
            end
        end
    endtask

    task automatic test_neg_zero();
        bias0[0] = 16'h8000;
        acc_tab[0] = 5;
        drive_cycle(1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 16'h0005 || s_ch !== 6'd0) begin
            errors++;
            $display("FAIL neg_zero got vld=%b data=%h ch=%0d exp 1 0005 0", s_valid, s_data, s_ch);
        end
        checks++;
        if (s_data !== e_data || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL neg_zero_model got data=%h busy=%b exp %h 1", s_data, s_busy, e_data);
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            bias0[c] = ((c % 2) == 1) ? (16'h8000 | 16'(c * 97)) : 16'(c * 211);
            bias1[c] = 16'h0000;
        end
        bias0[0]  = 16'h805E;
        bias0[36] = 16'h81FD;
        bias0[37] = 16'h02A6;
        bias1[0]  = 16'h805E;
        bias1[36] = 16'h81FD;
        for (int k = 0; k < TOTAL; k++) begin
            acc_tab[k] = int'($urandom_range(0, 80000)) - 40000;
        end
        acc_tab[0]  = 100;
        acc_tab[36] = 300;
        acc_tab[37] = 32700;
        model_reset();
        out_count = 0; ch63_count = 0; done_count = 0;

        test_reset();
        test_relu_off();
        test_basic();
        test_backpressure();
        test_framing();
        test_reset_mid();
        test_neg_zero();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/squeeze_bias_sequencer.md
# squeeze_bias_sequencer

Sequences the fire7 squeeze-layer bias/activation stage. It takes accumulator results in channel-major order (channels 0..CH-1 for each pixel) and selects the matching bias from the 64-entry sign-magnitude bias table. It adds the bias, applies optional ReLU and saturation, and emits 16-bit activations downstream under valid/ready flow control. It sits between the squeeze MAC array and the expand-layer input buffer, and frames one full layer pass per `start`.

## Interface
Parameters:
- CH, 64, output channels; also the bias table depth
- PIXELS, 169, spatial positions per layer pass (13x13)
- ACC_W, 32, accumulator width, two's complement
- OUT_W, 16, output width, two's complement
- RELU, 1, 1 = clamp negative results to 0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a layer pass (honoured only in IDLE)
- bias_mem  in  16 x CH  bias table; bit 15 = sign, bits 14:0 = magnitude
- acc_data  in  ACC_W  accumulator result
- acc_valid  in  1  acc_data is valid
- acc_ready  out  1  block accepts acc_data this cycle
- out_data  out  OUT_W  biased/activated result
- out_ch  out  log2(CH)  channel index of out_data
- out_valid  out  1  out_data/out_ch are valid
- out_ready  in  1  downstream accepts
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last result is accepted

## Operation
- FSM states:
  - IDLE: `start` -> RUN; counters cleared.
  - RUN: consumes beats. After the beat with ch_cnt==CH-1 and pix_cnt==PIXELS-1 is accepted on the input, go to DRAIN.
  - DRAIN: wait for the final out_valid&&out_ready -> DONE.
  - DONE: one cycle; done=1 -> IDLE.
- Input handshake: acc_ready = (state==RUN) && (!out_valid || out_ready). A beat transfers when acc_valid && acc_ready.
- Counters (advance only on an input transfer):
  - ch_cnt wraps CH-1 -> 0.
  - pix_cnt increments on each ch_cnt wrap.
  - Both clear in IDLE.
- Bias conversion, using b = bias_mem[ch_cnt]:
  - signed value = b[15] ? -b[14:0] : +b[14:0].
  - 16'h8000 (negative zero) is treated as 0.
  - Sign-extend to ACC_W+1 bits.
- Sum: s = acc_data + bias, computed in ACC_W+1 bits (no internal overflow).
- Activation:
  - If RELU and s<0, the result is 0.
  - Otherwise saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output register:
  - out_data/out_ch load on an input transfer; out_valid is set.
  - out_valid clears on out_ready when no new transfer occurs in the same cycle.
  - Simultaneous drain and load: the register is overwritten with the new beat and out_valid stays 1.
- `start` while busy is ignored. acc_valid outside RUN is ignored (acc_ready=0).
- bias_mem is static during a pass; no latching.

## Timing
- Reset values: state=IDLE, acc_ready=0, out_valid=0, out_data=0, out_ch=0, busy=0, done=0, counters=0.
- Reset mid-pass aborts immediately: pending output is discarded and no done pulse is produced.
- Latency is 1 cycle: a beat accepted at edge N gives out_valid=1 after edge N, with result visible in cycle N+1.
- Throughput is 1 beat/cycle while out_ready=1.
- out_data/out_ch are held stable while out_valid && !out_ready.
- busy rises the cycle after `start` is sampled in IDLE.
- done is high exactly one cycle, the cycle after the last output transfer; busy falls with the return to IDLE on the following edge.
- A pass contains exactly CH*PIXELS output transfers; out_ch follows the sequence 0..CH-1 repeating.

## Test plan
- Basic bias, RELU=1: start, ch0 acc=100 (bias 16'b1000000001011110 = -94) -> out_data=6, out_ch=0, one cycle after transfer.
- ReLU clamp: ch36 acc=300 (bias -509) -> out_data=0. Same with RELU=0 -> out_data=-209 (16'hFF2F).
- Saturation: ch37 acc=32700 (bias +678) -> 32767. With RELU=0, acc=-40000 on ch0 -> -32768.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> acc_ready=0, out_data/out_ch stable, no beat lost or duplicated. Then toggle out_ready every cycle -> all CH*PIXELS results arrive in order.
- Framing: full pass with random acc_valid gaps -> exactly 10816 outputs, out_ch wraps 63->0 169 times, single done pulse, busy drops. `start` issued mid-pass is ignored.
- Reset mid-pass: assert rst at pixel 50 -> all outputs 0 next cycle, no done. A new start then restarts at ch0/pix0; negative-zero bias 16'h8000 on acc=5 -> 5.
